// File: rtl/huffman_decoder_if.sv
// Huffman decoder bus: run control, code tables, serial bit handshake and
// decoded-symbol outputs, bundled so the decoder and its driver share one port.
interface huffman_decoder_if;

  logic       start;
  logic [7:0] total;
  logic [7:0] hc1;
  logic [7:0] hc2;
  logic [7:0] hc3;
  logic [7:0] hc4;
  logic [7:0] hc5;
  logic [7:0] hc6;
  logic [7:0] m1;
  logic [7:0] m2;
  logic [7:0] m3;
  logic [7:0] m4;
  logic [7:0] m5;
  logic [7:0] m6;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [2:0] sym;
  logic       sym_valid;
  logic       done;
  logic       err;

  // Driver side: issues runs and code bits, observes decoded symbols.
  modport master (
    output start, total,
    output hc1, hc2, hc3, hc4, hc5, hc6,
    output m1, m2, m3, m4, m5, m6,
    output bit_in, bit_valid,
    input  bit_ready, sym, sym_valid, done, err
  );

  // Decoder side.
  modport slave (
    input  start, total,
    input  hc1, hc2, hc3, hc4, hc5, hc6,
    input  m1, m2, m3, m4, m5, m6,
    input  bit_in, bit_valid,
    output bit_ready, sym, sym_valid, done, err
  );

endinterface

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder with six programmable codewords (up to 8 bits each).
// Bits are shifted into an accumulator MSB-first; after every accepted bit the
// accumulated prefix is compared against every codeword of exactly that length,
// the lowest-index hit is reported one cycle later, and the accumulator restarts.
// A run ends in DONE after 'total' symbols, or in ERR when 8 bits match nothing.
module huffman_decoder (
  input  logic             clk,
  input  logic             reset,
  huffman_decoder_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  logic [1:0] state;

  // Latched copy of the run parameters; inputs may change freely during a run.
  logic [7:0] hc_q [1:6];
  logic [7:0] m_q  [1:6];
  logic [7:0] total_q;

  // Decode datapath state.
  logic [7:0] acc;
  logic [3:0] len;
  logic [7:0] sym_cnt;

  // Registered outputs.
  logic [2:0] sym_q;
  logic       sym_valid_q;
  logic       done_q;
  logic       err_q;

  // Per-symbol input views so the matcher can loop over them.
  logic [7:0] hc_in [1:6];
  logic [7:0] m_in  [1:6];

  logic       load;
  logic       accept;
  logic [7:0] acc_n;
  logic [3:0] len_n;
  logic [7:0] len_mask;
  logic [7:0] sym_cnt_n;
  logic       last_sym;
  logic       hit;
  logic [2:0] hit_idx;
  logic       overflow;

  // Gather the individual table inputs into indexable arrays.
  always_comb begin
    hc_in[1] = bus.hc1;
    hc_in[2] = bus.hc2;
    hc_in[3] = bus.hc3;
    hc_in[4] = bus.hc4;
    hc_in[5] = bus.hc5;
    hc_in[6] = bus.hc6;
    m_in[1]  = bus.m1;
    m_in[2]  = bus.m2;
    m_in[3]  = bus.m3;
    m_in[4]  = bus.m4;
    m_in[5]  = bus.m5;
    m_in[6]  = bus.m6;
  end

  // A start only takes effect outside a run; bits are only taken during a run.
  assign load      = bus.start && (state != ST_RUN);
  assign accept    = bus.bit_valid && (state == ST_RUN);

  // Prefix after this bit, and the mask a codeword must carry to be that long.
  // len never rests at 8, so len_n stays in 1..8 and the shift stays in 0..7.
  assign acc_n     = {acc[6:0], bus.bit_in};
  assign len_n     = len + 4'd1;
  assign len_mask  = 8'hFF >> (4'd8 - len_n);
  assign overflow  = (len_n == 4'd8);

  assign sym_cnt_n = sym_cnt + 8'd1;
  assign last_sym  = (sym_cnt_n == total_q);

  // Codeword match; scan from the top so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    for (int i = 6; i >= 1; i--) begin
      if ((m_q[i] != 8'd0) && (m_q[i] == len_mask) &&
          ((acc_n & m_q[i]) == (hc_q[i] & m_q[i]))) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  // Capture the code tables and symbol count when a run is launched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i <= 6; i++) begin
        hc_q[i] <= 8'd0;
        m_q[i]  <= 8'd0;
      end
      total_q <= 8'd0;
    end else if (load) begin
      for (int i = 1; i <= 6; i++) begin
        hc_q[i] <= hc_in[i];
        m_q[i]  <= m_in[i];
      end
      total_q <= bus.total;
    end
  end

  // Run control: launch, finish after the last symbol, or fail on 8 dead bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept) begin
            if (hit && last_sym) begin
              state <= ST_DONE;
            end else if (!hit && overflow) begin
              state <= ST_ERR;
            end
          end
        end
        default: begin
          if (load) begin
            state <= (bus.total == 8'd0) ? ST_DONE : ST_RUN;
          end
        end
      endcase
    end
  end

  // Bit accumulator and symbol counter; a hit restarts the prefix.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= 8'd0;
      len     <= 4'd0;
      sym_cnt <= 8'd0;
    end else if (load) begin
      acc     <= 8'd0;
      len     <= 4'd0;
      sym_cnt <= 8'd0;
    end else if (accept) begin
      if (hit) begin
        acc     <= 8'd0;
        len     <= 4'd0;
        sym_cnt <= sym_cnt_n;
      end else if (!overflow) begin
        acc <= acc_n;
        len <= len_n;
      end
    end
  end

  // Symbol pulse plus sticky done/err status, all registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_q       <= 3'd0;
      sym_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sym_valid_q <= 1'b0;
      if (load) begin
        done_q <= (bus.total == 8'd0);
        err_q  <= 1'b0;
      end else if (accept) begin
        if (hit) begin
          sym_q       <= hit_idx;
          sym_valid_q <= 1'b1;
          if (last_sym) begin
            done_q <= 1'b1;
          end
        end else if (overflow) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.bit_ready = (state == ST_RUN);
  assign bus.sym       = sym_q;
  assign bus.sym_valid = sym_valid_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder. A reference model decodes the bit
// stream by comparing the accumulated prefix against each codeword's value
// and length; every cycle the DUT outputs are compared with the model.
module tb_huffman_decoder;

  logic clk;
  logic reset;

  huffman_decoder_if dif ();

  huffman_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  typedef enum int {M_IDLE, M_RUN, M_DONE, M_ERR} mstate_t;

  int checks = 0;
  int errors = 0;

  // Table the bench drives on start.
  logic [7:0] tab_hc [1:6];
  logic [7:0] tab_m  [1:6];

  // Reference model state.
  mstate_t mstate;
  int      ref_code [1:6];
  int      ref_len  [1:6];
  int      ref_total;
  int      ref_count;
  int      ref_val;
  int      ref_nbits;
  int      ref_last;
  logic    exp_pulse;

  // Observation log.
  logic [6:0] obs_vec;
  logic [6:0] exp_vec;
  int         cyc;
  int         pulse_cnt;
  int         pulse_pack;
  int         pos_pack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mstate    = M_IDLE;
    ref_last  = 0;
    ref_val   = 0;
    ref_nbits = 0;
    exp_pulse = 1'b0;
  endtask

  task automatic model_start(input int tot);
    if (mstate != M_RUN) begin
      for (int i = 1; i <= 6; i++) begin
        ref_len[i]  = $countones(tab_m[i]);
        ref_code[i] = int'(tab_hc[i] & tab_m[i]);
      end
      ref_total = tot;
      ref_count = 0;
      ref_val   = 0;
      ref_nbits = 0;
      mstate    = (tot == 0) ? M_DONE : M_RUN;
    end
  endtask

  task automatic model_bit(input logic b);
    int found;
    found     = 0;
    exp_pulse = 1'b0;
    if (mstate == M_RUN) begin
      ref_val = ref_val * 2 + int'(b);
      ref_nbits++;
      for (int i = 1; i <= 6; i++)
        if (found == 0 && ref_len[i] == ref_nbits && ref_code[i] == ref_val) found = i;
      if (found != 0) begin
        exp_pulse = 1'b1;
        ref_last  = found;
        ref_count++;
        ref_val   = 0;
        ref_nbits = 0;
        if (ref_count == ref_total) mstate = M_DONE;
      end else if (ref_nbits == 8) begin
        mstate = M_ERR;
      end
    end
  endtask

  task automatic sample();
    obs_vec = {dif.sym_valid, dif.sym, dif.done, dif.err, dif.bit_ready};
    exp_vec = {exp_pulse, 3'(ref_last), mstate == M_DONE, mstate == M_ERR, mstate == M_RUN};
    if (dif.sym_valid === 1'b1) begin
      pulse_cnt++;
      pulse_pack = pulse_pack * 8 + int'(dif.sym);
      pos_pack   = pos_pack * 16 + cyc;
    end
  endtask

  task automatic clear_log();
    cyc        = 0;
    pulse_cnt  = 0;
    pulse_pack = 0;
    pos_pack   = 0;
  endtask

  task automatic set_table_T();
    tab_hc = '{8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F};
    tab_m  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};
  endtask

  // Drive one cycle of the serial input, advance the model, sample outputs.
  task automatic applyStimulus(input logic v, input logic b);
    dif.bit_valid = v;
    dif.bit_in    = b;
    @(negedge clk);
    cyc++;
    if (v) model_bit(b);
    else exp_pulse = 1'b0;
    sample();
  endtask

  // Pulse start with the bench table, then scramble the table inputs.
  task automatic do_start(input int tot);
    dif.start     = 1'b1;
    dif.total     = 8'(tot);
    dif.bit_valid = 1'b0;
    dif.hc1 = tab_hc[1]; dif.hc2 = tab_hc[2]; dif.hc3 = tab_hc[3];
    dif.hc4 = tab_hc[4]; dif.hc5 = tab_hc[5]; dif.hc6 = tab_hc[6];
    dif.m1  = tab_m[1];  dif.m2  = tab_m[2];  dif.m3  = tab_m[3];
    dif.m4  = tab_m[4];  dif.m5  = tab_m[5];  dif.m6  = tab_m[6];
    @(negedge clk);
    model_start(tot);
    exp_pulse = 1'b0;
    dif.start = 1'b0;
    dif.total = 8'($urandom);
    dif.hc1 = 8'($urandom); dif.hc2 = 8'($urandom); dif.hc3 = 8'($urandom);
    dif.hc4 = 8'($urandom); dif.hc5 = 8'($urandom); dif.hc6 = 8'($urandom);
    dif.m1  = 8'($urandom); dif.m2  = 8'($urandom); dif.m3  = 8'($urandom);
    dif.m4  = 8'($urandom); dif.m5  = 8'($urandom); dif.m6  = 8'($urandom);
    sample();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    dif.start = 1'b0; dif.total = 8'd0; dif.bit_in = 1'b0; dif.bit_valid = 1'b0;
    dif.hc1 = 0; dif.hc2 = 0; dif.hc3 = 0; dif.hc4 = 0; dif.hc5 = 0; dif.hc6 = 0;
    dif.m1 = 0; dif.m2 = 0; dif.m3 = 0; dif.m4 = 0; dif.m5 = 0; dif.m6 = 0;
    model_reset();
    clear_log();
    repeat (2) @(negedge clk);
    sample();
    checks++;
    if (obs_vec !== 7'b0) begin
      errors++; $display("[TB] FAIL reset_outputs got %b want %b", obs_vec, 7'b0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL reset_nostart_c%0d got %b want %b", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_basic();
    logic [5:0] seq;
    seq = 6'b010110;
    set_table_T();
    clear_log();
    do_start(3);
    checks++;
    if (obs_vec !== exp_vec) begin
      errors++; $display("[TB] FAIL basic_start got %b want %b", obs_vec, exp_vec);
    end
    for (int i = 0; i < 8; i++) begin
      if (i < 6) applyStimulus(1'b1, seq[5-i]);
      else applyStimulus(1'b0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL basic_c%0d got %b want %b", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if (pulse_pack !== 'o123 || pulse_cnt !== 3) begin
      errors++; $display("[TB] FAIL basic_syms got %0o (%0d pulses) want 123 (3 pulses)", pulse_pack, pulse_cnt);
    end
    checks++;
    if (pos_pack !== 'h136) begin
      errors++; $display("[TB] FAIL basic_pulse_cycles got %0h want 136", pos_pack);
    end
    checks++;
    if (dif.done !== 1'b1 || dif.bit_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_final done=%b ready=%b want done=1 ready=0", dif.done, dif.bit_ready);
    end
  endtask

  task automatic test_long_stalls();
    logic [9:0] seq;
    seq = 10'b1111111110;
    set_table_T();
    clear_log();
    do_start(2);
    checks++;
    if (obs_vec !== exp_vec) begin
      errors++; $display("[TB] FAIL long_start got %b want %b", obs_vec, exp_vec);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, seq[9-i]);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL long_bit%0d got %b want %b", i, obs_vec, exp_vec);
      end
      for (int s = 0; s < 2; s++) begin
        applyStimulus(1'b0, 1'b1);
        checks++;
        if (obs_vec !== exp_vec) begin
          errors++; $display("[TB] FAIL long_stall%0d_%0d got %b want %b", i, s, obs_vec, exp_vec);
        end
      end
    end
    checks++;
    if (pulse_pack !== 'o65 || pos_pack !== (13 * 16 + 28) || dif.done !== 1'b1) begin
      errors++; $display("[TB] FAIL long_syms got syms %0o cycles %0d done %b want 65, %0d, 1",
                         pulse_pack, pos_pack, dif.done, 13 * 16 + 28);
    end
  endtask

  task automatic test_error();
    tab_hc = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tab_m  = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    clear_log();
    do_start(1);
    checks++;
    if (obs_vec !== exp_vec) begin
      errors++; $display("[TB] FAIL err_start got %b want %b", obs_vec, exp_vec);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL err_c%0d got %b want %b", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if (pulse_cnt !== 0 || dif.err !== 1'b1 || dif.bit_ready !== 1'b0 || dif.done !== 1'b0) begin
      errors++; $display("[TB] FAIL err_final pulses=%0d err=%b ready=%b done=%b want 0,1,0,0",
                         pulse_cnt, dif.err, dif.bit_ready, dif.done);
    end
  endtask

  task automatic test_total_zero();
    set_table_T();
    clear_log();
    do_start(0);
    checks++;
    if (dif.done !== 1'b1 || dif.bit_ready !== 1'b0 || dif.err !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_start done=%b ready=%b err=%b want 1,0,0", dif.done, dif.bit_ready, dif.err);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL zero_c%0d got %b want %b", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_start_in_run();
    logic [5:0] seq;
    seq = 6'b010110;
    set_table_T();
    clear_log();
    do_start(3);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        tab_hc = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        tab_m  = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        do_start(1);
        checks++;
        if (obs_vec !== exp_vec) begin
          errors++; $display("[TB] FAIL runstart_ignored got %b want %b", obs_vec, exp_vec);
        end
      end
      applyStimulus(1'b1, seq[5-i]);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL runstart_c%0d got %b want %b", i, obs_vec, exp_vec);
      end
    end
    applyStimulus(1'b0, 1'b0);
    checks++;
    if (pulse_pack !== 'o123 || dif.done !== 1'b1 || dif.bit_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL runstart_final syms %0o done %b ready %b want 123,1,0",
                         pulse_pack, dif.done, dif.bit_ready);
    end
  endtask

  task automatic test_reset_midrun();
    logic [2:0] seq;
    seq = 3'b010;
    set_table_T();
    clear_log();
    do_start(3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, seq[2-i]);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL midrst_c%0d got %b want %b", i, obs_vec, exp_vec);
      end
    end
    dif.bit_valid = 1'b1;
    dif.bit_in    = 1'b1;
    #2 reset = 1'b0;
    #1;
    model_reset();
    sample();
    checks++;
    if (obs_vec !== 7'b0) begin
      errors++; $display("[TB] FAIL midrst_async got %b want %b", obs_vec, 7'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_log();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL midrst_idle_c%0d got %b want %b", i, obs_vec, exp_vec);
      end
    end
    do_start(1);
    applyStimulus(1'b1, 1'b0);
    checks++;
    if (obs_vec !== exp_vec) begin
      errors++; $display("[TB] FAIL midrst_restart got %b want %b", obs_vec, exp_vec);
    end
    checks++;
    if (pulse_pack !== 1 || dif.done !== 1'b1) begin
      errors++; $display("[TB] FAIL midrst_final syms %0o done %b want 1,1", pulse_pack, dif.done);
    end
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic q[$];
    int   n;
    int   s;
    int   l;
    int   first;
    logic b;
    for (int run = 0; run < 12; run++) begin
      for (int i = 1; i <= 6; i++) begin
        l = $urandom_range(0, 8);
        tab_m[i]  = 8'hFF >> (8 - l);
        tab_hc[i] = 8'($urandom);
      end
      s = $urandom_range(1, 6);
      if (tab_m[s] == 8'd0) tab_m[s] = 8'hFF >> (8 - $urandom_range(1, 8));
      clear_log();
      q.delete();
      do_start($urandom_range(1, 4));
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL rand%0d_start got %b want %b", run, obs_vec, exp_vec);
      end
      n = 0;
      while (mstate == M_RUN && n < 200) begin
        if ($urandom_range(0, 3) == 0) begin
          applyStimulus(1'b0, 1'($urandom));
        end else begin
          if (q.size() == 0) begin
            first = $urandom_range(0, 5);
            s = 0;
            for (int k = 0; k < 6; k++)
              if (s == 0 && tab_m[((first + k) % 6) + 1] != 8'd0) s = ((first + k) % 6) + 1;
            l = $countones(tab_m[s]);
            for (int k = l - 1; k >= 0; k--) q.push_back(tab_hc[s][k]);
          end
          b = q.pop_front();
          if ($urandom_range(0, 15) == 0) b = ~b;
          applyStimulus(1'b1, b);
        end
        checks++;
        if (obs_vec !== exp_vec) begin
          errors++; $display("[TB] FAIL rand%0d_c%0d got %b want %b", run, n, obs_vec, exp_vec);
        end
        n++;
      end
      applyStimulus(1'b0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec || mstate == M_RUN) begin
        errors++; $display("[TB] FAIL rand%0d_end got %b want %b (cycles %0d)", run, obs_vec, exp_vec, n);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_long_stalls();
    test_error();
    test_total_zero();
    test_start_in_run();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
